// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
package prog_seq_pkg;
  localparam int CNT_W     = 16;
  localparam int DEF_BASE0 = 0;
  localparam int DEF_BASE1 = 100;
  localparam int DEF_BASE2 = 200;

  typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/start_edge_det.sv
// Registers Start and decodes single-cycle rise/fall pulses.
module start_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic rise,
  output logic fall
);
  logic start_r;
  logic seen_low;

  // seen_low blocks a rise from a Start that was already high when reset released
  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_r  <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      start_r <= start;
      if (!start) seen_low <= 1'b1;
    end
  end

  assign rise = start & ~start_r & seen_low;
  assign fall = ~start & start_r;
endmodule

// File: rtl/prog_sequencer.sv
// Selects one of three programs on Start pulses and sequences the PC through load/run/done.
//   state | meaning
//   IDLE  | no program requested since reset, PC frozen
//   ARMED | request accepted, waiting for Start to fall
//   LOAD  | PC loads the selected base address
//   RUN   | program executing, cycles counted
//   DONE  | halt seen, PC frozen until next request
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int A     = 10,
  parameter int BASE0 = DEF_BASE0,
  parameter int BASE1 = DEF_BASE1,
  parameter int BASE2 = DEF_BASE2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             HaltInstr,
  output logic             PcLoad,
  output logic [A-1:0]     PcTarget,
  output logic             PcHold,
  output logic             Done,
  output logic [1:0]       ProgIdx,
  output logic [CNT_W-1:0] CycleCount
);
  localparam logic [A-1:0] B0 = A'(BASE0);
  localparam logic [A-1:0] B1 = A'(BASE1);
  localparam logic [A-1:0] B2 = A'(BASE2);

  state_t     state, state_nxt;
  logic [1:0] idx_nxt;
  logic       rise, fall, accept;

  start_edge_det u_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .start (Start),
    .rise  (rise),
    .fall  (fall)
  );

  function automatic logic [A-1:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd2:    base_of = B1;
      2'd3:    base_of = B2;
      default: base_of = B0;
    endcase
  endfunction

  assign accept = rise && (ProgIdx != 2'd3);

  // A new request in RUN takes priority over a simultaneous halt
  always_comb begin
    state_nxt = state;
    idx_nxt   = ProgIdx;
    case (state)
      IDLE, DONE: if (accept) begin
        state_nxt = ARMED;
        idx_nxt   = ProgIdx + 2'd1;
      end
      ARMED: if (fall) state_nxt = LOAD;
      LOAD:  state_nxt = RUN;
      RUN: begin
        if (accept) begin
          state_nxt = ARMED;
          idx_nxt   = ProgIdx + 2'd1;
        end else if (HaltInstr) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgIdx    <= 2'd0;
      CycleCount <= '0;
      PcLoad     <= 1'b0;
      PcHold     <= 1'b1;
      Done       <= 1'b0;
      PcTarget   <= B0;
    end else begin
      state    <= state_nxt;
      ProgIdx  <= idx_nxt;
      PcLoad   <= (state_nxt == LOAD);
      PcHold   <= (state_nxt == IDLE) || (state_nxt == ARMED) || (state_nxt == DONE);
      Done     <= (state_nxt == DONE);
      PcTarget <= base_of(idx_nxt);
      if (state_nxt == LOAD)
        CycleCount <= '0;
      else if (state == RUN && CycleCount != '1)
        CycleCount <= CycleCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed vector bench for prog_sequencer: cycle table plus saturation sequence.
module tb_prog_sequencer;
  logic        Clk = 1'b0;
  logic        Reset, Start, HaltInstr;
  logic        PcLoad, PcHold, Done;
  logic [9:0]  PcTarget;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, start, halt;
    logic        load, hold, done;
    logic [1:0]  idx;
    logic [9:0]  tgt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  prog_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .HaltInstr  (HaltInstr),
    .PcLoad     (PcLoad),
    .PcTarget   (PcTarget),
    .PcHold     (PcHold),
    .Done       (Done),
    .ProgIdx    (ProgIdx),
    .CycleCount (CycleCount)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic r, s, h, l, hd, d, input logic [1:0] i,
                              input logic [9:0] t, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.start = s; v.halt = h;
    v.load = l; v.hold = hd; v.done = d; v.idx = i; v.tgt = t; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, s, h);
    @(negedge Clk);
    Reset = r; Start = s; HaltInstr = h;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic l, hd, d, input logic [1:0] i,
                         input logic [9:0] t, input logic [15:0] c);
    chk({tag, ".PcLoad"},     16'(PcLoad),   16'(l));
    chk({tag, ".PcHold"},     16'(PcHold),   16'(hd));
    chk({tag, ".Done"},       16'(Done),     16'(d));
    chk({tag, ".ProgIdx"},    16'(ProgIdx),  16'(i));
    chk({tag, ".PcTarget"},   16'(PcTarget), 16'(t));
    chk({tag, ".CycleCount"}, CycleCount,    c);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; HaltInstr = 1'b0;

    //              rst s h  load hold done idx tgt  cnt
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,   0, 0));   // 0 reset
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1,   0, 0));   // rise -> ARMED
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1,   0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1,   0, 0));   // fall -> LOAD
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0));   // RUN
    for (int k = 1; k <= 6; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 16'(k)));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1,   0, 7));   // 13 halt -> DONE
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,   0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,   0, 7));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 2, 100, 7));   // 16 program 2
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 100, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 100, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 100, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 2, 100, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 3, 200, 2));   // 21 program 3
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 200, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 200, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 3, 200, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 3, 200, 1));   // 25 fourth request ignored
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 200, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,   0, 0));   // 27 reset
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1,   0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 2, 100, 2));   // 33 rise beats halt
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 2, 100, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 100, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 100, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0,   0, 0));   // 37 reset in RUN, Start high
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0,   0, 0));   // held Start is not a rise
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1,   0, 0));   // 41 fresh rise -> ARMED

    for (int v = 0; v < vecs.size(); v++) begin
      step(vecs[v].rst, vecs[v].start, vecs[v].halt);
      chk_all($sformatf("vec%0d", v), vecs[v].load, vecs[v].hold, vecs[v].done,
              vecs[v].idx, vecs[v].tgt, vecs[v].cnt);
    end

    // Long RUN: counter saturates at 65535 and never wraps
    step(0, 0, 0);
    chk_all("sat_load", 1, 0, 0, 1, 0, 0);
    step(0, 0, 0);
    chk_all("sat_run0", 0, 0, 0, 1, 0, 0);
    repeat (65534) step(0, 0, 0);
    chk("sat_65534", CycleCount, 16'd65534);
    step(0, 0, 0);
    chk("sat_65535", CycleCount, 16'hFFFF);
    repeat (4500) step(0, 0, 0);
    chk("sat_hold", CycleCount, 16'hFFFF);
    chk("sat_pchold", 16'(PcHold), 16'd0);
    step(0, 0, 1);
    chk_all("sat_done", 0, 1, 1, 1, 0, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
